dpi_stream_sequencer: RTL and testbench
=======================================

Name: dpi_stream_sequencer

Overview:
- Front-end controller for the bank of per-regex DFA wrappers. It accepts a byte-serial packet stream tagged with a flow key and maps each key to a 6-bit stream id through a 64-entry tag table.
- It sequences every wrapper: load_state/new_stream_id at packet start, a gated char_in_vld during the body, and a single eop pulse after the DFA pipeline drains.
- All wrappers in the bank share its outputs.

Parameters:
- KEY_W, 16, width of flow key.
- NUM_REGEX, 8, number of wrappers driven; width of enable vector.
- LOAD_LAT, 2, cycles from load_state until the wrapper's restored state is valid at the DFA input.
- DRAIN_LAT, 3, cycles from the last char_in_vld until state_out_r is final.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  byte valid
- in_rdy  out  1  byte accepted when in_vld & in_rdy
- in_sop  in  1  first byte of packet; qualified by in_vld
- in_eop  in  1  last byte of packet; qualified by in_vld
- in_data  in  8  packet byte
- in_key  in  KEY_W  flow key; sampled on the sop beat
- cfg_enable  in  NUM_REGEX  regex enable mask; sampled on the sop beat
- char_in  out  8  byte to wrappers
- char_in_vld  out  1  byte valid to wrappers
- load_state  out  1  one-cycle state restore pulse
- new_stream_id  out  1  valid with load_state; stream freshly allocated
- stream_id  out  6  current stream id; stable from load_state through eop
- eop  out  1  one-cycle commit pulse
- enable  out  NUM_REGEX  latched mask; stable from load_state through eop
- busy  out  1  FSM not IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0; FSM goes to IDLE.
  - All table valid bits clear; victim pointer = 0.
  - Reset mid-packet abandons the packet with no eop. Wrapper state is not committed.
- FSM states: IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, COMMIT.
- IDLE:
  - in_rdy = 1 only while in_vld & in_sop is absent.
  - A non-sop byte arriving in IDLE is accepted and dropped.
  - On in_vld & in_sop, hold in_rdy = 0, latch key and cfg_enable, go to LOOKUP. The sop beat itself is not consumed yet.
- LOOKUP (1 cycle):
  - Parallel compare of the key against all valid tags.
  - Hit: stream_id = matching index, new_stream_id = 0.
  - Miss: use the lowest-index invalid entry if any; otherwise the entry at the victim pointer, then victim pointer += 1 mod 64. Write the tag, set valid, new_stream_id = 1.
  - Multiple hits cannot occur.
  - Go to LOAD.
- LOAD: assert load_state for 1 cycle, then WAIT for LOAD_LAT-1 cycles. (LOAD_LAT = 1 means no WAIT.)
- STREAM:
  - in_rdy = 1.
  - Each accepted beat drives char_in = in_data and char_in_vld = 1 in the next cycle (1-cycle registered).
  - Bubbles on in_vld produce char_in_vld = 0.
  - The accepted beat with in_eop goes to DRAIN. If that beat is also the sop beat (single-byte packet), the same rule applies.
  - A sop arriving mid-packet is treated as data; no resync.
- DRAIN: in_rdy = 0; count DRAIN_LAT cycles after the last char_in_vld.
- COMMIT: assert eop for 1 cycle, then go to IDLE.
- Latency per packet (sop seen to eop pulse) = 1 + 1 + LOAD_LAT + N + DRAIN_LAT cycles, assuming no bubbles.
- load_state and eop are never asserted in the same cycle.
- Back-to-back packets have at least one IDLE cycle between eop and the next load_state.
- stream_id, new_stream_id and enable hold their values from LOAD until COMMIT completes.

Optional Feature:
- Macro DPI_SEQ_STATS_EN.
- When defined, adds these outputs: pkt_cnt[31:0], byte_cnt[31:0], evict_cnt[15:0].
  - pkt_cnt increments at COMMIT.
  - byte_cnt increments per char_in_vld.
  - evict_cnt increments when a miss replaces a valid entry.
  - All counters wrap and reset to 0.
- When undefined, the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package dpi_seq_pkg holds:
  - FSM state enum;
  - STREAM_ID_W = 6;
  - NUM_STREAMS = 64.
- One sub-module, dpi_stream_table: tag/valid storage, parallel compare, free-entry priority encoder, victim pointer.
  - Inputs: lookup strobe and key.
  - Outputs: id and new flag, registered, 1 cycle.

Test Plan:
- Reset, then a 4-byte packet with key 0x1234 → load_state with new_stream_id = 1, stream_id = 0; four char_in_vld beats; eop exactly DRAIN_LAT+1 cycles after the last beat.
- Second packet with key 0x1234 → stream_id = 0, new_stream_id = 0. A third packet with key 0xBEEF → stream_id = 1, new_stream_id = 1.
- 64 distinct keys, then a 65th → stream_id = 0 (eviction), then 66th → stream_id = 1. Replaying the first key afterward misses; with the feature enabled, evict_cnt = 2.
- Single-byte packet (sop & eop on the same beat) → exactly one char_in_vld, then a single eop pulse. in_vld bubbles mid-packet → char_in_vld gaps match the input and eop still follows the last byte.
- Assert rst during STREAM → outputs 0 next cycle, no eop. A later packet with the previously seen key → new_stream_id = 1.
- cfg_enable = 0xA5 at sop with a change to 0x00 mid-packet → enable = 0xA5 held through eop.

Source files
------------

// File: rtl/dpi_seq_pkg.sv
// Shared types and constants for the DPI stream sequencer and its tag table.
// Holds the sequencer FSM state encoding and the stream-id sizing.
package dpi_seq_pkg;

    localparam int STREAM_ID_W = 6;
    localparam int NUM_STREAMS = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_COMMIT = 3'd6
    } seq_state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [STREAM_ID_W-1:0] lowest_set(input logic [NUM_STREAMS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = STREAM_ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// 64-entry flow-key tag table: parallel compare, lowest-free allocation and a
// round-robin victim pointer once full. Result (id, new flag) is registered.
module dpi_stream_table
    import dpi_seq_pkg::*;
#(
    parameter int KEY_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lookup,
    input  logic [KEY_W-1:0]       key,
    output logic [STREAM_ID_W-1:0] id,
    output logic                   new_stream,
    output logic                   evict
);

    logic [KEY_W-1:0]       tag_q [NUM_STREAMS];
    logic [KEY_W-1:0]       tag_d [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_q, valid_d;
    logic [STREAM_ID_W-1:0] victim_q, victim_d;
    logic [STREAM_ID_W-1:0] id_q, id_d;
    logic                   new_q, new_d;
    logic                   evict_q, evict_d;

    logic [NUM_STREAMS-1:0] hit_vec;
    logic [NUM_STREAMS-1:0] free_vec;
    logic                   any_hit;
    logic                   any_free;
    logic [STREAM_ID_W-1:0] alloc_idx;

    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == key);
        end
        free_vec  = ~valid_q;
        any_hit   = |hit_vec;
        any_free  = |free_vec;
        alloc_idx = any_free ? lowest_set(free_vec) : victim_q;
    end

    always_comb begin
        tag_d    = tag_q;
        valid_d  = valid_q;
        victim_d = victim_q;
        id_d     = id_q;
        new_d    = new_q;
        evict_d  = 1'b0;
        if (lookup) begin
            if (any_hit) begin
                id_d  = lowest_set(hit_vec);
                new_d = 1'b0;
            end else begin
                id_d               = alloc_idx;
                new_d              = 1'b1;
                tag_d[alloc_idx]   = key;
                valid_d[alloc_idx] = 1'b1;
                // Victim only advances when a live entry is actually replaced.
                if (!any_free) begin
                    victim_d = victim_q + STREAM_ID_W'(1);
                    evict_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            victim_q <= '0;
            id_q     <= '0;
            new_q    <= 1'b0;
            evict_q  <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            victim_q <= victim_d;
            id_q     <= id_d;
            new_q    <= new_d;
            evict_q  <= evict_d;
        end
    end

    assign id         = id_q;
    assign new_stream = new_q;
    assign evict      = evict_q;

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Front-end sequencer for the DFA wrapper bank: key lookup, state load, gated
// byte stream, drain and commit. Define DPI_SEQ_STATS_EN for packet/byte/evict counters.
module dpi_stream_sequencer
    import dpi_seq_pkg::*;
#(
    parameter int KEY_W     = 16,
    parameter int NUM_REGEX = 8,
    parameter int LOAD_LAT  = 2,
    parameter int DRAIN_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [7:0]             in_data,
    input  logic [KEY_W-1:0]       in_key,
    input  logic [NUM_REGEX-1:0]   cfg_enable,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   load_state,
    output logic                   new_stream_id,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   eop,
    output logic [NUM_REGEX-1:0]   enable,
`ifdef DPI_SEQ_STATS_EN
    output logic [31:0]            pkt_cnt,
    output logic [31:0]            byte_cnt,
    output logic [15:0]            evict_cnt,
`endif
    output logic                   busy
);

    localparam int CNT_W = 8;

    // Handshake: a byte transfers on any cycle where in_vld && in_rdy; in_vld
    // never waits on in_rdy, and the sop beat is held off until STREAM.
    seq_state_e           state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [NUM_REGEX-1:0] enable_q, enable_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           char_q, char_d;
    logic                 char_vld_q, char_vld_d;
    logic                 load_state_q, load_state_d;
    logic                 eop_q, eop_d;
    logic                 busy_q, busy_d;
    logic                 tbl_evict;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        enable_d   = enable_q;
        cnt_d      = cnt_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        in_rdy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy = !(in_vld && in_sop);
                if (in_vld && in_sop) begin
                    key_d    = in_key;
                    enable_d = cfg_enable;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_LOAD;
            ST_LOAD: begin
                if (LOAD_LAT > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LOAD_LAT - 2);
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_STREAM;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_STREAM: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    char_d     = in_data;
                    char_vld_d = 1'b1;
                    if (in_eop) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(DRAIN_LAT - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_COMMIT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (rst) in_rdy = 1'b0;
        load_state_d = (state_d == ST_LOAD);
        eop_d        = (state_d == ST_COMMIT);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            enable_q     <= '0;
            cnt_q        <= '0;
            char_q       <= '0;
            char_vld_q   <= 1'b0;
            load_state_q <= 1'b0;
            eop_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            enable_q     <= enable_d;
            cnt_q        <= cnt_d;
            char_q       <= char_d;
            char_vld_q   <= char_vld_d;
            load_state_q <= load_state_d;
            eop_q        <= eop_d;
            busy_q       <= busy_d;
        end
    end

    dpi_stream_table #(
        .KEY_W (KEY_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .lookup     (state_q == ST_LOOKUP),
        .key        (key_q),
        .id         (stream_id),
        .new_stream (new_stream_id),
        .evict      (tbl_evict)
    );

    assign char_in     = char_q;
    assign char_in_vld = char_vld_q;
    assign load_state  = load_state_q;
    assign eop         = eop_q;
    assign enable      = enable_q;
    assign busy        = busy_q;

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] evict_cnt_q, evict_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q + ((state_q == ST_COMMIT) ? 32'd1 : 32'd0);
        byte_cnt_d  = byte_cnt_q + (char_vld_q ? 32'd1 : 32'd0);
        evict_cnt_d = evict_cnt_q + (tbl_evict ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            evict_cnt_q <= evict_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign byte_cnt  = byte_cnt_q;
    assign evict_cnt = evict_cnt_q;
`else
    logic unused_evict;
    assign unused_evict = tbl_evict;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: lookup/allocation, eviction, bubbles,
// single-byte packets, mid-packet reset and enable latching.
module tb_dpi_stream_sequencer;

    localparam int KEY_W     = 16;
    localparam int NUM_REGEX = 8;
    localparam int LOAD_LAT  = 2;
    localparam int DRAIN_LAT = 3;

    logic                 clk;
    logic                 rst;
    logic                 in_vld;
    logic                 in_rdy;
    logic                 in_sop;
    logic                 in_eop;
    logic [7:0]           in_data;
    logic [KEY_W-1:0]     in_key;
    logic [NUM_REGEX-1:0] cfg_enable;
    logic [7:0]           char_in;
    logic                 char_in_vld;
    logic                 load_state;
    logic                 new_stream_id;
    logic [5:0]           stream_id;
    logic                 eop;
    logic [NUM_REGEX-1:0] enable;
    logic                 busy;
`ifdef DPI_SEQ_STATS_EN
    logic [31:0]          pkt_cnt;
    logic [31:0]          byte_cnt;
    logic [15:0]          evict_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dpi_stream_sequencer #(
        .KEY_W     (KEY_W),
        .NUM_REGEX (NUM_REGEX),
        .LOAD_LAT  (LOAD_LAT),
        .DRAIN_LAT (DRAIN_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_data       (in_data),
        .in_key        (in_key),
        .cfg_enable    (cfg_enable),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .new_stream_id (new_stream_id),
        .stream_id     (stream_id),
        .eop           (eop),
        .enable        (enable),
`ifdef DPI_SEQ_STATS_EN
        .pkt_cnt       (pkt_cnt),
        .byte_cnt      (byte_cnt),
        .evict_cnt     (evict_cnt),
`endif
        .busy          (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        in_vld  = 1'b0;
        in_sop  = 1'b0;
        in_eop  = 1'b0;
        in_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_char_vld"}, char_in_vld, 1'b0);
        chk({tag, "_char"}, char_in, 8'h00);
        chk({tag, "_load"}, load_state, 1'b0);
        chk({tag, "_new"}, new_stream_id, 1'b0);
        chk({tag, "_id"}, stream_id, 6'd0);
        chk({tag, "_eop"}, eop, 1'b0);
        chk({tag, "_enable"}, enable, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Drives one packet and checks it cycle by cycle; abort_at >= 0 stops
    // driving once that many bytes have been accepted (no eop expected).
    task automatic send_pkt(input logic [15:0] key, input int n, input logic [7:0] en,
                            input logic [7:0] en_mid, input logic bubble,
                            input logic exp_new, input logic [5:0] exp_id, input int abort_at);
        int idx, c0, load_cyc, eop_cyc, last_acc, first_acc, loads, eops, nvld, budget;
        logic prev_acc, acc, done;
        logic [7:0] exp_q[$];
        idx = 0; loads = 0; eops = 0; nvld = 0; budget = 0;
        c0 = -1; load_cyc = -1; eop_cyc = -1; last_acc = -1; first_acc = -1;
        prev_acc = 1'b0; done = 1'b0;
        while (!done && budget < 300) begin
            @(posedge clk); #1;
            if (c0 < 0) c0 = cyc;
            if (idx < n && !(bubble && prev_acc && idx > 0)) begin
                in_vld  = 1'b1;
                in_sop  = (idx == 0);
                in_eop  = (idx == n - 1);
                in_data = key[7:0] + 8'(idx * 17);
                in_key  = key;
            end else begin
                idle_inputs();
            end
            cfg_enable = (idx == 0) ? en : en_mid;
            @(negedge clk);
            acc = in_vld & in_rdy;
            chk("char_vld_follows_accept", char_in_vld, prev_acc);
            if (char_in_vld) begin
                nvld++;
                if (exp_q.size() > 0) chk("char_data", char_in, exp_q.pop_front());
            end
            chk("load_eop_exclusive", load_state & eop, 1'b0);
            if (load_state) begin
                loads++;
                load_cyc = cyc;
                chk("load_new_id", new_stream_id, exp_new);
                chk("load_stream_id", stream_id, exp_id);
            end
            if (eop) begin
                eops++;
                eop_cyc = cyc;
                chk("eop_enable", enable, en);
                chk("eop_stream_id", stream_id, exp_id);
                chk("eop_new_id", new_stream_id, exp_new);
                done = 1'b1;
            end
            if (acc) begin
                exp_q.push_back(in_data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                idx++;
            end
            prev_acc = acc;
            if (abort_at >= 0 && idx >= abort_at) done = 1'b1;
            budget++;
        end
        idle_inputs();
        chk("pkt_done_in_budget", done, 1'b1);
        chk("load_latency", 64'(load_cyc - c0), 64'(2));
        chk("first_accept_latency", 64'(first_acc - c0), 64'(2 + LOAD_LAT));
        if (abort_at < 0) begin
            chk("load_count", loads, 1);
            chk("eop_count", eops, 1);
            chk("char_vld_count", nvld, n);
            chk("eop_after_last_beat", 64'(eop_cyc - last_acc), 64'(DRAIN_LAT + 1));
            if (!bubble) chk("pkt_latency", 64'(eop_cyc - c0), 64'(2 + LOAD_LAT + n + DRAIN_LAT));
        end
    endtask

    initial begin
        int eops;
        rst = 1'b1;
        idle_inputs();
        in_key     = '0;
        cfg_enable = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        chk("reset_in_rdy", in_rdy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_rdy", in_rdy, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // New key allocates entry 0, repeat hits, second key gets entry 1
        send_pkt(16'h1234, 4, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'd0, -1);
        send_pkt(16'h1234, 3, 8'h0F, 8'h0F, 1'b0, 1'b0, 6'd0, -1);
        send_pkt(16'hBEEF, 2, 8'h3C, 8'h3C, 1'b0, 1'b1, 6'd1, -1);
        // Single-byte packet, then a packet with in_vld bubbles
        send_pkt(16'hBEEF, 1, 8'h01, 8'h01, 1'b0, 1'b0, 6'd1, -1);
        send_pkt(16'h0042, 5, 8'h81, 8'h81, 1'b1, 1'b1, 6'd2, -1);
        // Enable mask latched at sop, ignored mid-packet
        send_pkt(16'h1234, 4, 8'hA5, 8'h00, 1'b0, 1'b0, 6'd0, -1);

        // Reset during STREAM: abandoned packet, no eop, table cleared
        send_pkt(16'h7777, 6, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'd3, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        eops = 0;
        repeat (12) begin
            @(negedge clk);
            if (eop) eops++;
        end
        chk("midreset_no_eop", eops, 0);
        send_pkt(16'h1234, 2, 8'h11, 8'h11, 1'b0, 1'b1, 6'd0, -1);

        // Fill all 64 entries, then evict entries 0 and 1 in order
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send_pkt(16'h1000 + 16'(i), 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'(i), -1);
        end
        send_pkt(16'h2000, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'd0, -1);
        send_pkt(16'h2001, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'd1, -1);
`ifdef DPI_SEQ_STATS_EN
        @(negedge clk);
        chk("stats_evict_cnt", evict_cnt, 16'd2);
        chk("stats_pkt_cnt", pkt_cnt, 32'd66);
        chk("stats_byte_cnt", byte_cnt, 32'd66);
`endif
        // First key was evicted: misses and takes the next victim slot
        send_pkt(16'h1000, 1, 8'hFF, 8'hFF, 1'b0, 1'b1, 6'd2, -1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
